// File: rtl/svc_rv_mem_arb.sv
// Two-requester arbiter in front of a single-port BRAM with 1-cycle read latency.
// Round-robin or fixed priority, bounded lock, read responses routed back to the issuer.
module svc_rv_mem_arb #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int RR       = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_valid,
    output logic            m0_ready,
    input  logic            m0_we,
    input  logic            m0_lock,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_valid,
    output logic            m1_ready,
    input  logic            m1_we,
    input  logic            m1_lock,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            mem_ren,
    output logic [AW-1:0]   mem_raddr,
    input  logic [DW-1:0]   mem_rdata,
    output logic            mem_wen,
    output logic [AW-1:0]   mem_waddr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb
);
    localparam int CW = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;

    // rr_pref is the requester favoured on the next tie (the inverse of the last
    // grant); resetting it to 0 makes m0 win the first tie after reset.
    logic          rr_pref;
    logic          lock_owner_vld;
    logic          lock_owner;
    logic [CW-1:0] lock_cnt;
    logic          rd_pend;
    logic          rd_owner;

    logic          gnt_vld;
    logic          gnt_id;
    logic          lock_act;
    logic          sel_we;
    logic          sel_lock;
    logic          owner_valid;

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = 1'b0;
        lock_act = (LOCK_MAX > 0) && lock_owner_vld && (lock_cnt < CW'(LOCK_MAX));
        if (rst_n && (m0_valid || m1_valid)) begin
            gnt_vld = 1'b1;
            if (m0_valid && m1_valid)
                gnt_id = lock_act ? lock_owner : ((RR != 0) ? rr_pref : 1'b0);
            else
                gnt_id = m1_valid;
        end
    end

    assign sel_we      = gnt_id ? m1_we   : m0_we;
    assign sel_lock    = gnt_id ? m1_lock : m0_lock;
    assign owner_valid = lock_owner ? m1_valid : m0_valid;

    assign m0_ready  = gnt_vld && !gnt_id;
    assign m1_ready  = gnt_vld &&  gnt_id;

    assign mem_ren   = gnt_vld && !sel_we;
    assign mem_wen   = gnt_vld &&  sel_we;
    assign mem_raddr = gnt_id ? m1_addr  : m0_addr;
    assign mem_waddr = mem_raddr;
    assign mem_wdata = gnt_id ? m1_wdata : m0_wdata;
    assign mem_wstrb = gnt_id ? m1_wstrb : m0_wstrb;

    assign m0_rvalid = rd_pend && !rd_owner;
    assign m1_rvalid = rd_pend &&  rd_owner;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_pref        <= 1'b0;
            lock_owner_vld <= 1'b0;
            lock_owner     <= 1'b0;
            lock_cnt       <= '0;
            rd_pend        <= 1'b0;
            rd_owner       <= 1'b0;
        end else begin
            rd_pend  <= mem_ren;
            rd_owner <= gnt_id;
            if (gnt_vld)
                rr_pref <= ~gnt_id;
            if (LOCK_MAX > 0) begin
                // A locked accept (re)claims the lock; anything else drops it.
                if (gnt_vld && sel_lock) begin
                    lock_owner_vld <= 1'b1;
                    lock_owner     <= gnt_id;
                    if (lock_owner_vld && (lock_owner == gnt_id)) begin
                        if (lock_cnt != CW'(LOCK_MAX))
                            lock_cnt <= lock_cnt + CW'(1);
                    end else begin
                        lock_cnt <= CW'(1);
                    end
                end else if (gnt_vld || (lock_owner_vld && !owner_valid)) begin
                    lock_owner_vld <= 1'b0;
                    lock_cnt       <= '0;
                end
            end
        end
    end

    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n) !(m0_ready && m1_ready));
    a_one_op:    assert property (@(posedge clk) disable iff (!rst_n) !(mem_ren && mem_wen));
    a_rv0:       assert property (@(posedge clk) disable iff (!rst_n)
                     m0_rvalid |-> $past(m0_valid && m0_ready && !m0_we));
    a_rv1:       assert property (@(posedge clk) disable iff (!rst_n)
                     m1_rvalid |-> $past(m1_valid && m1_ready && !m1_we));
endmodule

// File: tb/tb_svc_rv_mem_arb.sv
// Scoreboard bench: RR/lock instance fully checked, fixed-priority instance checked on grants.
module tb_svc_rv_mem_arb;
    localparam int AW = 10, DW = 32, SW = 4, LMAX = 4;

    typedef struct { bit v; bit we; bit lk; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s; } req_t;
    typedef struct { int cyc; bit r0; bit r1; bit f0; bit f1; bit ren; bit wen; } gnt_t;
    typedef struct { int due; int owner; logic [DW-1:0] data; } rd_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic m0_valid = 0, m0_we = 0, m0_lock = 0, m1_valid = 0, m1_we = 0, m1_lock = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic [SW-1:0] m0_wstrb = '0, m1_wstrb = '0;

    logic m0_ready, m0_rvalid, m1_ready, m1_rvalid, mem_ren, mem_wen;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [SW-1:0] mem_wstrb;

    logic f_m0_ready, f_m0_rvalid, f_m1_ready, f_m1_rvalid, f_mem_ren, f_mem_wen;
    logic [DW-1:0] f_m0_rdata, f_m1_rdata, f_mem_wdata;
    logic [AW-1:0] f_mem_raddr, f_mem_waddr;
    logic [SW-1:0] f_mem_wstrb;

    svc_rv_mem_arb #(.AW(AW), .DW(DW), .RR(1), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb));

    svc_rv_mem_arb #(.AW(AW), .DW(DW), .RR(0), .LOCK_MAX(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(f_m0_ready), .m0_we(m0_we), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(f_m1_ready), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
        .mem_ren(f_mem_ren), .mem_raddr(f_mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(f_mem_wen), .mem_waddr(f_mem_waddr), .mem_wdata(f_mem_wdata), .mem_wstrb(f_mem_wstrb));

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        if (a == 10'h010) return 32'hDEADBEEF;
        if (a == 10'h020) return 32'hAAAAAAAA;
        return 32'hC0DE0000 | 32'(a);
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] w, logic [SW-1:0] s);
        logic [DW-1:0] r = old;
        for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    // Behavioural BRAM driven by the DUT under test
    logic [DW-1:0] bram [1024];
    logic [1023:0] bram_wr = '0;
    function automatic logic [DW-1:0] bval(logic [AW-1:0] a);
        return bram_wr[a] ? bram[a] : init_val(a);
    endfunction
    always @(posedge clk) begin
        if (mem_wen) begin
            bram[mem_waddr]    <= merge(bval(mem_waddr), mem_wdata, mem_wstrb);
            bram_wr[mem_waddr] <= 1'b1;
        end
        if (mem_ren) mem_rdata <= bval(mem_raddr);
    end

    // Reference model state
    logic [DW-1:0] ref_mem [1024];
    int pref, own, cnt, fpref, fown, fcnt;
    int cyc = 0, checks = 0, failures = 0;
    gnt_t gnt_q[$];
    rd_t  rd_q[$];

    function automatic void mstep(input bit v0, input bit v1, input bit l0, input bit l1,
                                  input int rr, input int lmax,
                                  inout int p, inout int o, inout int c, output int g);
        g = -1;
        if (v0 && v1) begin
            if (lmax > 0 && o >= 0 && c < lmax) g = o;
            else g = (rr != 0) ? p : 0;
        end else if (v0) g = 0;
        else if (v1) g = 1;
        if (g >= 0) begin
            p = 1 - g;
            if (lmax > 0 && ((g == 0) ? l0 : l1)) begin
                c = (o == g) ? ((c < lmax) ? c + 1 : lmax) : 1;
                o = g;
            end else begin
                o = -1; c = 0;
            end
        end else begin
            o = -1; c = 0;
        end
    endfunction

    function automatic req_t mk(bit v, bit we, bit lk, int a, logic [DW-1:0] d, logic [SW-1:0] s);
        req_t r;
        r.v = v; r.we = we; r.lk = lk; r.a = AW'(a); r.d = d; r.s = s;
        return r;
    endfunction

    int last_g;
    task automatic drive(input bit rst, input req_t q0, input req_t q1);
        int g, gf;
        gnt_t e;
        rd_t r;
        req_t qs;
        @(posedge clk); #1;
        cyc++;
        rst_n = rst;
        m0_valid = q0.v; m0_we = q0.we; m0_lock = q0.lk; m0_addr = q0.a; m0_wdata = q0.d; m0_wstrb = q0.s;
        m1_valid = q1.v; m1_we = q1.we; m1_lock = q1.lk; m1_addr = q1.a; m1_wdata = q1.d; m1_wstrb = q1.s;
        if (!rst) begin
            pref = 0; own = -1; cnt = 0; fpref = 0; fown = -1; fcnt = 0;
            rd_q.delete();
            g = -1; gf = -1;
        end else begin
            mstep(q0.v, q1.v, q0.lk, q1.lk, 1, LMAX, pref, own, cnt, g);
            mstep(q0.v, q1.v, q0.lk, q1.lk, 0, 0, fpref, fown, fcnt, gf);
        end
        qs = (g == 1) ? q1 : q0;
        e.cyc = cyc; e.r0 = (g == 0); e.r1 = (g == 1); e.f0 = (gf == 0); e.f1 = (gf == 1);
        e.ren = (g >= 0) && !qs.we; e.wen = (g >= 0) && qs.we;
        gnt_q.push_back(e);
        if (g >= 0) begin
            if (qs.we) ref_mem[qs.a] = merge(ref_mem[qs.a], qs.d, qs.s);
            else begin
                r.due = cyc + 1; r.owner = g; r.data = ref_mem[qs.a];
                rd_q.push_back(r);
            end
        end
        last_g = g;
    endtask

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", n, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        gnt_t e;
        rd_t r;
        if (gnt_q.size() > 0) begin
            e = gnt_q.pop_front();
            chk("m0_ready", 32'(m0_ready), 32'(e.r0));
            chk("m1_ready", 32'(m1_ready), 32'(e.r1));
            chk("fp_m0_ready", 32'(f_m0_ready), 32'(e.f0));
            chk("fp_m1_ready", 32'(f_m1_ready), 32'(e.f1));
            chk("mem_ren", 32'(mem_ren), 32'(e.ren));
            chk("mem_wen", 32'(mem_wen), 32'(e.wen));
        end
        if (m0_rvalid || m1_rvalid) begin
            if (rd_q.size() == 0 || rd_q[0].due != cyc) begin
                checks++; failures++;
                $display("FAIL unexpected_rvalid cyc=%0d actual=%b%b expected=00", cyc, m1_rvalid, m0_rvalid);
            end else begin
                r = rd_q.pop_front();
                chk("rvalid_pair", {30'b0, m1_rvalid, m0_rvalid}, (r.owner == 1) ? 32'd2 : 32'd1);
                chk("rdata", (r.owner == 1) ? m1_rdata : m0_rdata, r.data);
            end
        end
        while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            r = rd_q.pop_front();
            checks++; failures++;
            $display("FAIL missing_rvalid cyc=%0d actual=none expected=m%0d data %h", cyc, r.owner, r.data);
        end
    end

    req_t idle, q0, q1;
    initial begin
        int idx, guard;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(AW'(i));
        pref = 0; own = -1; cnt = 0; fpref = 0; fown = -1; fcnt = 0;
        idle = mk(0, 0, 0, 0, 0, 0);

        // Reset held with both requesters asserting: nothing may be granted
        repeat (2) drive(0, mk(1, 0, 0, 1, 0, 0), mk(1, 1, 1, 2, 32'h1, 4'hF));

        // Single read from m0, then write-then-read with partial strobes
        drive(1, mk(1, 0, 0, 10'h010, 0, 0), idle);
        drive(1, idle, idle);
        drive(1, mk(1, 1, 0, 10'h020, 32'h11223344, 4'b0011), idle);
        drive(1, mk(1, 0, 0, 10'h020, 0, 0), idle);
        drive(1, idle, idle);
        checks++;
        if (ref_mem[10'h020] !== 32'hAAAA3344) begin
            failures++;
            $display("FAIL strobe_model actual=%h expected=aaaa3344", ref_mem[10'h020]);
        end

        // Both reading continuously, then m0 drops
        repeat (6) drive(1, mk(1, 0, 0, 1, 0, 0), mk(1, 0, 0, 2, 0, 0));
        drive(1, idle, mk(1, 0, 0, 2, 0, 0));
        drive(1, idle, idle);

        // Locked m1 block write against a continuously reading m0
        idx = 0; guard = 0;
        while (idx < 16 && guard < 64) begin
            drive(1, mk(1, 0, 0, 10'h0F0, 0, 0), mk(1, 1, 1, 10'h100 + idx, 32'hB000_0000 + 32'(idx), 4'hF));
            if (last_g == 1) idx++;
            guard++;
        end
        chk("lock_burst_done", 32'(idx), 32'd16);
        drive(1, idle, idle);

        // Randomized traffic over a narrow address window
        for (int n = 0; n < 500; n++) begin
            q0 = mk($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 31), $urandom, 4'($urandom));
            q1 = mk($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31), $urandom, 4'($urandom));
            drive(1, q0, q1);
        end

        // Reset immediately after an accepted m1 read
        drive(1, idle, mk(1, 0, 0, 5, 0, 0));
        drive(0, mk(1, 0, 0, 6, 0, 0), mk(1, 0, 1, 7, 0, 0));
        drive(0, mk(1, 0, 0, 6, 0, 0), mk(1, 0, 1, 7, 0, 0));
        drive(1, mk(1, 0, 0, 6, 0, 0), mk(1, 0, 0, 7, 0, 0));
        drive(1, mk(1, 0, 0, 6, 0, 0), mk(1, 0, 0, 7, 0, 0));

        for (int n = 0; n < 200; n++) begin
            q0 = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 31), $urandom, 4'($urandom));
            q1 = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 31), $urandom, 4'($urandom));
            drive(1, q0, q1);
        end
        repeat (3) drive(1, idle, idle);
        @(posedge clk); #2;

        for (int a = 0; a < 32; a++) chk("final_mem", bval(AW'(a)), ref_mem[a]);
        for (int a = 10'h100; a < 10'h110; a++) chk("final_lock_mem", bval(AW'(a)), 32'hB000_0000 + 32'(a - 10'h100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
